// File: rtl/cv32e40x_skid_register_if.sv
// cv32e40x_skid_register_if: valid/ready bus between producer, skid register and consumer
interface cv32e40x_skid_register_if #(
  parameter int WORD_WIDTH = 32
);
  logic                  valid_in;
  logic                  ready_out;
  logic [WORD_WIDTH-1:0] data_in;
  logic                  valid_out;
  logic                  ready_in;
  logic [WORD_WIDTH-1:0] data_out;
  modport slave (input valid_in, data_in, ready_in, output ready_out, valid_out, data_out);
  modport master (output valid_in, data_in, ready_in, input ready_out, valid_out, data_out);
endinterface

// File: rtl/cv32e40x_skid_register.sv
// cv32e40x_skid_register: two-entry valid/ready pipeline register with fully registered ready_out
module cv32e40x_skid_register #(
  parameter int                    WORD_WIDTH  = 32,
  parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0
) (
  input logic                      clk,
  input logic                      rst_n,
  input logic                      flush,
  cv32e40x_skid_register_if.slave  bus
);
  // State bits are {valid_out, ready_out}, so both outputs come straight from flops
  typedef enum logic [1:0] {EMPTY = 2'b01, BUSY = 2'b11, FULL = 2'b10} state_e;
  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] main_q, skid_q;
  logic                  in_hs, out_hs, main_ld, skid_ld, main_from_skid;
  assign bus.ready_out = state_q[0];
  assign bus.valid_out = state_q[1];
  assign bus.data_out  = main_q;
  assign in_hs         = bus.valid_in & bus.ready_out;
  assign out_hs        = bus.valid_out & bus.ready_in;
  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        main_ld = in_hs;
        state_d = in_hs ? BUSY : EMPTY;
      end
      BUSY: begin
        main_ld = in_hs & out_hs;
        skid_ld = in_hs & ~out_hs;
        state_d = (in_hs & ~out_hs) ? FULL : (out_hs & ~in_hs) ? EMPTY : BUSY;
      end
      FULL: begin
        main_ld        = out_hs;
        main_from_skid = out_hs;
        state_d        = out_hs ? BUSY : FULL;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= RESET_VALUE;
      skid_q <= RESET_VALUE;
    end else if (flush) begin
      main_q <= RESET_VALUE;
      skid_q <= RESET_VALUE;
    end else begin
      if (main_ld) main_q <= main_from_skid ? skid_q : bus.data_in;
      if (skid_ld) skid_q <= bus.data_in;
    end
  end
endmodule
